dcm_prog_responder: RTL and testbench
=====================================

// Module: dcm_prog_responder
// PURPOSE
//  Synthesizable responder for the DCM_CLKGEN serial PROG port: the DCM end of the link that dcm_controller drives.
//  Deserializes LoadD/LoadM/GO frames on dcm_prog_en/dcm_prog_data and applies the staged config on GO.
//  Drives dcm_prog_done after a fixed latency.
//  Used as a loopback checker in hardware self-test and as a DCM stand-in in simulation.
// PARAMETERS
//  GO_LATENCY          32  cycles dcm_prog_done stays low after an accepted GO (>=1)
//  MAXIMUM_MULTIPLIER  64  largest legal M; a larger decoded M is rejected
//  MAXIMUM_DIVIDER     256 largest legal D
//  INITIAL_MULTIPLIER  16  multiplier value after reset
//  INITIAL_DIVIDER     8   divider value after reset
// PORTS
//  clk            in   1  sole clock; all inputs are sampled on posedge
//  reset          in   1  synchronous, active-high
//  dcm_prog_en    in   1  PROGEN from the controller
//  dcm_prog_data  in   1  PROGDATA from the controller
//  dcm_prog_done  out  1  PROGDONE
//  multiplier     out  8  applied M (true value, not M-1)
//  divider        out  9  applied D (true value, 1..256)
//  cfg_update     out  1  1-cycle pulse when multiplier/divider change
//  proto_err      out  1  1-cycle pulse on any protocol violation
//  err_code       out  3  code of the last error; holds until the next error
// BEHAVIOUR
//  Reset values: dcm_prog_done=1, multiplier=INITIAL_MULTIPLIER, divider=INITIAL_DIVIDER.
//    cfg_update=0, proto_err=0, err_code=0. Staged D/M are invalid. FSM=IDLE.
//  Frame format: en held 1 for 10 cycles; bits b0,b1 = command; 8 data bits follow, LSB first.
//    Data values are value-1. Command 10 = LoadD, 11 = LoadM.
//  GO: en=1 for exactly 1 cycle with data=0 while in IDLE.
//  FSM states: IDLE -> CMD (en=1,data=1 seen) -> DATA (cnt 0..7) -> GAP -> IDLE.
//  IDLE: en=1 & data=0 -> GO handling; en=0 -> stay in IDLE.
//  CMD: the next cycle's data bit selects D/M; en must remain 1.
//  DATA: shifts in 8 bits LSB first. After bit 7 the value is staged (D=val+1, M=val+1) and its valid bit is set.
//  GAP: en must be 0 for >=1 cycle before the next frame or GO. en=1 -> error 3, then return to IDLE.
//  en drop in CMD/DATA -> error 1 (truncated frame); staged value unchanged; return to IDLE.
//  GO: requires both D and M staged; missing either -> error 2.
//    Staged M outside [2, MAXIMUM_MULTIPLIER] -> error 4; staged D > MAXIMUM_DIVIDER -> error 5.
//    On error: no config change and dcm_prog_done stays 1.
//    On an accepted GO, on the same edge that samples GO:
//      - dcm_prog_done <= 0, held low for GO_LATENCY cycles;
//      - on the edge where dcm_prog_done returns to 1, update multiplier/divider and pulse cfg_update.
//    Staged valid bits clear on every GO, accepted or not.
//  GO while a GO latency is still running -> error 6 and ignored; the latency counter continues.
//  Frames received during the latency are decoded and staged normally.
//  proto_err pulses on the error edge; err_code is updated on the same edge.
//  Reset mid-frame or mid-latency: reset values are restored immediately and dcm_prog_done=1 the next cycle.
//  Arithmetic: 8-bit value + 1 is computed 9 bits wide, so D=256 is representable. Latency counter is clog2(GO_LATENCY+1) bits.
// CONFIGURATION
//  DCM_PROG_STATS_EN defined: adds outputs go_count[15:0] (accepted GOs) and err_count[15:0] (errors).
//    Both counters saturate at 16'hFFFF and clear on reset.
//  DCM_PROG_STATS_EN not defined: neither port nor counters exist.
// STRUCTURE
//  Shared include dcm_prog_defs.vh holds:
//    - command encodings CMD_LOADD=2'b10, CMD_LOADM=2'b11;
//    - FSM state encodings;
//    - err_code values 0..6.
//  dcm_controller includes the same file.
//  Sub-module dcm_prog_frame_rx: bit-level FSM and shifter.
//    Outputs: frame_done, frame_is_m, frame_val[7:0], go_seen, err pulses.
//  Top level holds the staging registers, range checks, latency counter and stats.
// TESTING
//  1. LoadD 0x07, LoadM 0x1F, GO -> done low 32 cycles; then multiplier=32, divider=8, single cfg_update.
//  2. Exact dcm_controller sequence with multiplier=50 -> multiplier=50, divider=8, no proto_err.
//  3. en drops after 4 data bits -> proto_err, err_code=1; a later GO with only M staged -> err_code=2.
//  4. LoadM 0x00 (M=1) then GO -> err_code=4, multiplier unchanged, done stays 1.
//  5. GO during latency -> err_code=6; original update still occurs at cycle 32.
//  6. Reset asserted in DATA and mid-latency -> done=1 and multiplier=16 next cycle; a fresh frame then decodes.

Source files
------------

// File: rtl/dcm_prog_responder_pkg.sv
// Shared encodings for the DCM_CLKGEN PROG-port responder: command codes,
// receiver FSM states and error codes.
package dcm_prog_responder_pkg;

    localparam logic [1:0] CMD_LOADD = 2'b10;
    localparam logic [1:0] CMD_LOADM = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } rx_state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_TRUNC   = 3'd1;
    localparam logic [2:0] ERR_MISSING = 3'd2;
    localparam logic [2:0] ERR_GAP     = 3'd3;
    localparam logic [2:0] ERR_M_RANGE = 3'd4;
    localparam logic [2:0] ERR_D_RANGE = 3'd5;
    localparam logic [2:0] ERR_GO_BUSY = 3'd6;

    // Frame payloads carry value-1; widen before adding so 0xFF becomes 256.
    function automatic logic [8:0] plus_one(input logic [7:0] v);
        return {1'b0, v} + 9'd1;
    endfunction

endpackage

// File: rtl/dcm_prog_frame_rx.sv
// Bit-level receiver for PROGEN/PROGDATA: recognises GO and LoadD/LoadM
// frames and flags truncated frames and missing inter-frame gaps.
module dcm_prog_frame_rx
    import dcm_prog_responder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       dcm_prog_en,
    input  logic       dcm_prog_data,
    output logic       frame_done,
    output logic       frame_is_m,
    output logic [7:0] frame_val,
    output logic       go_seen,
    output logic       err_trunc,
    output logic       err_gap
);

    rx_state_t  state;
    rx_state_t  state_next;
    logic [2:0] cnt;
    logic [6:0] shreg;
    logic       is_m;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
            shreg <= 7'd0;
            is_m  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_CMD && dcm_prog_en) begin
                is_m <= ({1'b1, dcm_prog_data} == CMD_LOADM);
                cnt  <= 3'd0;
            end
            if (state == ST_DATA && dcm_prog_en) begin
                shreg <= {dcm_prog_data, shreg[6:1]};
                cnt   <= cnt + 3'd1;
            end
        end
    end

    // The eighth data bit is taken straight from the pin so the value is
    // available on the same edge that samples it.
    assign frame_val  = {dcm_prog_data, shreg};
    assign frame_is_m = is_m;

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        go_seen    = 1'b0;
        err_trunc  = 1'b0;
        err_gap    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dcm_prog_en) begin
                    if (dcm_prog_data) begin
                        state_next = ST_CMD;
                    end else begin
                        go_seen = 1'b1;
                    end
                end
            end
            ST_CMD: begin
                if (!dcm_prog_en) begin
                    err_trunc  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!dcm_prog_en) begin
                    err_trunc  = 1'b1;
                    state_next = ST_IDLE;
                end else if (cnt == 3'd7) begin
                    frame_done = 1'b1;
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                err_gap    = dcm_prog_en;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/dcm_prog_responder.sv
// DCM end of the DCM_CLKGEN PROG link: stages D/M, validates GO, applies the
// config after GO_LATENCY cycles. Optional counters: DCM_PROG_STATS_EN.
module dcm_prog_responder
    import dcm_prog_responder_pkg::*;
#(
    parameter int GO_LATENCY         = 32,
    parameter int MAXIMUM_MULTIPLIER = 64,
    parameter int MAXIMUM_DIVIDER    = 256,
    parameter int INITIAL_MULTIPLIER = 16,
    parameter int INITIAL_DIVIDER    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dcm_prog_en,
    input  logic        dcm_prog_data,
    output logic        dcm_prog_done,
    output logic [7:0]  multiplier,
    output logic [8:0]  divider,
    output logic        cfg_update,
    output logic        proto_err,
    output logic [2:0]  err_code
`ifdef DCM_PROG_STATS_EN
    ,
    output logic [15:0] go_count,
    output logic [15:0] err_count
`endif
);

    localparam int LAT_W = $clog2(GO_LATENCY + 1);

    logic             frame_done;
    logic             frame_is_m;
    logic [7:0]       frame_val;
    logic             go_seen;
    logic             err_trunc;
    logic             err_gap;

    logic [8:0]       staged_m;
    logic [8:0]       staged_d;
    logic             m_valid;
    logic             d_valid;
    logic [7:0]       pend_m;
    logic [8:0]       pend_d;
    logic [LAT_W-1:0] lat_cnt;

    logic             busy;
    logic             accept;
    logic             err_now;
    logic [2:0]       err_val;

    dcm_prog_frame_rx u_rx (
        .clk           (clk),
        .reset         (reset),
        .dcm_prog_en   (dcm_prog_en),
        .dcm_prog_data (dcm_prog_data),
        .frame_done    (frame_done),
        .frame_is_m    (frame_is_m),
        .frame_val     (frame_val),
        .go_seen       (go_seen),
        .err_trunc     (err_trunc),
        .err_gap       (err_gap)
    );

    assign busy          = (lat_cnt != '0);
    assign dcm_prog_done = !busy;

    // A GO during a running latency is rejected before any staging checks.
    always_comb begin
        accept  = 1'b0;
        err_now = 1'b0;
        err_val = ERR_NONE;
        if (err_trunc) begin
            err_now = 1'b1;
            err_val = ERR_TRUNC;
        end else if (err_gap) begin
            err_now = 1'b1;
            err_val = ERR_GAP;
        end else if (go_seen) begin
            err_now = 1'b1;
            if (busy) begin
                err_val = ERR_GO_BUSY;
            end else if (!(m_valid && d_valid)) begin
                err_val = ERR_MISSING;
            end else if (staged_m < 9'd2 || staged_m > 9'(MAXIMUM_MULTIPLIER)) begin
                err_val = ERR_M_RANGE;
            end else if (staged_d > 9'(MAXIMUM_DIVIDER)) begin
                err_val = ERR_D_RANGE;
            end else begin
                err_now = 1'b0;
                accept  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            multiplier <= 8'(INITIAL_MULTIPLIER);
            divider    <= 9'(INITIAL_DIVIDER);
            cfg_update <= 1'b0;
            proto_err  <= 1'b0;
            err_code   <= ERR_NONE;
            staged_m   <= 9'd0;
            staged_d   <= 9'd0;
            m_valid    <= 1'b0;
            d_valid    <= 1'b0;
            pend_m     <= 8'd0;
            pend_d     <= 9'd0;
            lat_cnt    <= '0;
        end else begin
            cfg_update <= 1'b0;
            proto_err  <= err_now;
            if (err_now) begin
                err_code <= err_val;
            end
            if (frame_done) begin
                if (frame_is_m) begin
                    staged_m <= plus_one(frame_val);
                    m_valid  <= 1'b1;
                end else begin
                    staged_d <= plus_one(frame_val);
                    d_valid  <= 1'b1;
                end
            end
            if (go_seen) begin
                m_valid <= 1'b0;
                d_valid <= 1'b0;
            end
            // The config lands on the same edge that raises dcm_prog_done.
            if (accept) begin
                lat_cnt <= LAT_W'(GO_LATENCY);
                pend_m  <= staged_m[7:0];
                pend_d  <= staged_d;
            end else if (busy) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
                if (lat_cnt == LAT_W'(1)) begin
                    multiplier <= pend_m;
                    divider    <= pend_d;
                    cfg_update <= 1'b1;
                end
            end
        end
    end

`ifdef DCM_PROG_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            go_count  <= 16'd0;
            err_count <= 16'd0;
        end else begin
            if (accept && go_count != 16'hFFFF) begin
                go_count <= go_count + 16'd1;
            end
            if (err_now && err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcm_prog_responder.sv
// Directed self-checking bench for dcm_prog_responder (default parameters).
module tb_dcm_prog_responder;

    logic       clk;
    logic       reset;
    logic       dcm_prog_en;
    logic       dcm_prog_data;
    logic       dcm_prog_done;
    logic [7:0] multiplier;
    logic [8:0] divider;
    logic       cfg_update;
    logic       proto_err;
    logic [2:0] err_code;
`ifdef DCM_PROG_STATS_EN
    logic [15:0] go_count;
    logic [15:0] err_count;
`endif

    int vectors;
    int miscompares;
    int cyc;
    int cfg_pulses;
    int err_pulses;

    dcm_prog_responder dut (
        .clk           (clk),
        .reset         (reset),
        .dcm_prog_en   (dcm_prog_en),
        .dcm_prog_data (dcm_prog_data),
        .dcm_prog_done (dcm_prog_done),
        .multiplier    (multiplier),
        .divider       (divider),
        .cfg_update    (cfg_update),
        .proto_err     (proto_err),
        .err_code      (err_code)
`ifdef DCM_PROG_STATS_EN
        ,
        .go_count      (go_count),
        .err_count     (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and observe registered outputs 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cfg_update) cfg_pulses++;
        if (proto_err) err_pulses++;
    endtask

    task automatic send_bit(input logic en, input logic d);
        dcm_prog_en   = en;
        dcm_prog_data = d;
        tick();
    endtask

    task automatic send_frame(input logic is_m, input logic [7:0] val);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, is_m);
        for (int i = 0; i < 8; i++) send_bit(1'b1, val[i]);
        send_bit(1'b0, 1'b0);
    endtask

    task automatic send_go();
        send_bit(1'b1, 1'b0);
        dcm_prog_en   = 1'b0;
        dcm_prog_data = 1'b0;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        dcm_prog_en   = 1'b0;
        dcm_prog_data = 1'b0;
        tick();
        tick();
        reset      = 1'b0;
        cfg_pulses = 0;
        err_pulses = 0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!dcm_prog_done && n < 200) begin
            tick();
            n++;
        end
        vectors++;
        if (!dcm_prog_done) begin
            miscompares++;
            $display("[TB] FAIL wait_done timeout got done=%0d required=1", dcm_prog_done);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (dcm_prog_done !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_done got=%0d exp=1", dcm_prog_done); end
        vectors++; if (multiplier !== 8'd16) begin miscompares++; $display("[TB] FAIL rst_mult got=%0d exp=16", multiplier); end
        vectors++; if (divider !== 9'd8) begin miscompares++; $display("[TB] FAIL rst_div got=%0d exp=8", divider); end
        vectors++; if (cfg_update !== 1'b0 || proto_err !== 1'b0 || err_code !== 3'd0) begin miscompares++; $display("[TB] FAIL rst_flags got cfg=%0d perr=%0d code=%0d exp 0/0/0", cfg_update, proto_err, err_code); end
    endtask

    task automatic test_basic();
        int n;
        do_reset();
        send_frame(1'b0, 8'h07);
        send_frame(1'b1, 8'h1F);
        send_go();
        vectors++; if (dcm_prog_done !== 1'b0) begin miscompares++; $display("[TB] FAIL t1_done_low got=%0d exp=0", dcm_prog_done); end
        wait_done(n);
        vectors++; if (n != 32) begin miscompares++; $display("[TB] FAIL t1_latency got=%0d exp=32", n); end
        vectors++; if (multiplier !== 8'd32) begin miscompares++; $display("[TB] FAIL t1_mult got=%0d exp=32", multiplier); end
        vectors++; if (divider !== 9'd8) begin miscompares++; $display("[TB] FAIL t1_div got=%0d exp=8", divider); end
        vectors++; if (cfg_update !== 1'b1) begin miscompares++; $display("[TB] FAIL t1_cfg_edge got=%0d exp=1", cfg_update); end
        tick();
        vectors++; if (cfg_pulses != 1 || cfg_update !== 1'b0) begin miscompares++; $display("[TB] FAIL t1_cfg_single got pulses=%0d now=%0d exp 1/0", cfg_pulses, cfg_update); end
    endtask

    task automatic test_controller_seq();
        int n;
        do_reset();
        send_frame(1'b0, 8'd7);
        send_frame(1'b1, 8'd49);
        send_go();
        wait_done(n);
        tick();
        vectors++; if (multiplier !== 8'd50) begin miscompares++; $display("[TB] FAIL t2_mult got=%0d exp=50", multiplier); end
        vectors++; if (divider !== 9'd8) begin miscompares++; $display("[TB] FAIL t2_div got=%0d exp=8", divider); end
        vectors++; if (err_pulses != 0) begin miscompares++; $display("[TB] FAIL t2_no_err got=%0d exp=0", err_pulses); end
    endtask

    task automatic test_truncate_missing();
        do_reset();
        send_frame(1'b1, 8'h1F);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        vectors++; if (proto_err !== 1'b1 || err_code !== 3'd1) begin miscompares++; $display("[TB] FAIL t3_trunc got perr=%0d code=%0d exp 1/1", proto_err, err_code); end
        tick();
        vectors++; if (proto_err !== 1'b0 || err_code !== 3'd1) begin miscompares++; $display("[TB] FAIL t3_hold got perr=%0d code=%0d exp 0/1", proto_err, err_code); end
        send_go();
        vectors++; if (proto_err !== 1'b1 || err_code !== 3'd2) begin miscompares++; $display("[TB] FAIL t3_missing got perr=%0d code=%0d exp 1/2", proto_err, err_code); end
        vectors++; if (dcm_prog_done !== 1'b1 || multiplier !== 8'd16) begin miscompares++; $display("[TB] FAIL t3_nochange got done=%0d mult=%0d exp 1/16", dcm_prog_done, multiplier); end
    endtask

    task automatic test_gap_and_range();
        do_reset();
        send_frame(1'b0, 8'h07);
        for (int i = 0; i < 2; i++) send_bit(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        vectors++; if (proto_err !== 1'b1 || err_code !== 3'd3) begin miscompares++; $display("[TB] FAIL gap_err got perr=%0d code=%0d exp 1/3", proto_err, err_code); end
        send_bit(1'b0, 1'b0);
        send_go();
        vectors++; if (err_code !== 3'd4 || dcm_prog_done !== 1'b1) begin miscompares++; $display("[TB] FAIL t4_m1 got code=%0d done=%0d exp 4/1", err_code, dcm_prog_done); end
        send_frame(1'b0, 8'h00);
        send_frame(1'b1, 8'h40);
        send_go();
        vectors++; if (err_code !== 3'd4 || proto_err !== 1'b1) begin miscompares++; $display("[TB] FAIL m65 got code=%0d perr=%0d exp 4/1", err_code, proto_err); end
        for (int i = 0; i < 3; i++) tick();
        vectors++; if (multiplier !== 8'd16 || cfg_pulses != 0 || dcm_prog_done !== 1'b1) begin miscompares++; $display("[TB] FAIL t4_unchanged got mult=%0d cfg=%0d done=%0d exp 16/0/1", multiplier, cfg_pulses, dcm_prog_done); end
    endtask

    task automatic test_bounds();
        int n;
        do_reset();
        send_frame(1'b0, 8'hFF);
        send_frame(1'b1, 8'h3F);
        send_go();
        wait_done(n);
        vectors++; if (multiplier !== 8'd64 || divider !== 9'd256) begin miscompares++; $display("[TB] FAIL max_bounds got mult=%0d div=%0d exp 64/256", multiplier, divider); end
        send_frame(1'b1, 8'h01);
        send_frame(1'b0, 8'h00);
        send_go();
        wait_done(n);
        vectors++; if (multiplier !== 8'd2 || divider !== 9'd1 || err_pulses != 0) begin miscompares++; $display("[TB] FAIL min_bounds got mult=%0d div=%0d errs=%0d exp 2/1/0", multiplier, divider, err_pulses); end
    endtask

    task automatic test_back_to_back();
        int n;
        int go_cyc;
        do_reset();
        send_frame(1'b0, 8'h07);
        send_frame(1'b1, 8'h1F);
        send_go();
        go_cyc = cyc;
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        send_go();
        vectors++; if (proto_err !== 1'b1 || err_code !== 3'd6 || dcm_prog_done !== 1'b0) begin miscompares++; $display("[TB] FAIL t5_busy got perr=%0d code=%0d done=%0d exp 1/6/0", proto_err, err_code, dcm_prog_done); end
        send_frame(1'b0, 8'h0F);
        send_frame(1'b1, 8'h04);
        wait_done(n);
        vectors++; if (cyc - go_cyc != 32) begin miscompares++; $display("[TB] FAIL t5_latency got=%0d exp=32", cyc - go_cyc); end
        vectors++; if (multiplier !== 8'd32 || divider !== 9'd8) begin miscompares++; $display("[TB] FAIL t5_first got mult=%0d div=%0d exp 32/8", multiplier, divider); end
        send_go();
        wait_done(n);
        vectors++; if (multiplier !== 8'd5 || divider !== 9'd16 || cfg_pulses != 2) begin miscompares++; $display("[TB] FAIL t5_staged got mult=%0d div=%0d cfg=%0d exp 5/16/2", multiplier, divider, cfg_pulses); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dcm_prog_en = 1'b0;
        vectors++; if (dcm_prog_done !== 1'b1 || multiplier !== 8'd16) begin miscompares++; $display("[TB] FAIL t6_data got done=%0d mult=%0d exp 1/16", dcm_prog_done, multiplier); end
        send_frame(1'b0, 8'h07);
        send_frame(1'b1, 8'h1F);
        send_go();
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if (dcm_prog_done !== 1'b1 || multiplier !== 8'd16 || divider !== 9'd8) begin miscompares++; $display("[TB] FAIL t6_lat got done=%0d mult=%0d div=%0d exp 1/16/8", dcm_prog_done, multiplier, divider); end
        cfg_pulses = 0;
        for (int i = 0; i < 30; i++) tick();
        vectors++; if (cfg_pulses != 0 || multiplier !== 8'd16) begin miscompares++; $display("[TB] FAIL t6_no_late got cfg=%0d mult=%0d exp 0/16", cfg_pulses, multiplier); end
        send_frame(1'b0, 8'h03);
        send_frame(1'b1, 8'h09);
        send_go();
        wait_done(n);
        vectors++; if (multiplier !== 8'd10 || divider !== 9'd4) begin miscompares++; $display("[TB] FAIL t6_fresh got mult=%0d div=%0d exp 10/4", multiplier, divider); end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        cyc           = 0;
        cfg_pulses    = 0;
        err_pulses    = 0;
        reset         = 1'b1;
        dcm_prog_en   = 1'b0;
        dcm_prog_data = 1'b0;
        test_reset();
        test_basic();
        test_controller_seq();
        test_truncate_missing();
        test_gap_and_range();
        test_bounds();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
